pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the enable/clear controls of the fetch and decode pipeline registers and the clear of the execute register, and generates decode- and execute-stage forwarding selects. It also tracks a multi-cycle multiply/divide unit so that HI/LO reads stall until the result is ready. It sits beside the datapath in the top-level CPU and is the only source of `enable`/`clr` for the pipeline registers.

## Interface
Parameters:
- `MD_LATENCY`, 32, busy cycles of the mult/div unit after issue; legal range 1–255.

Ports:
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs_d`, `rt_d` in 5: source registers of the instruction in decode.
- `rs_e`, `rt_e` in 5: source registers of the instruction in execute.
- `write_reg_e`, `write_reg_m`, `write_reg_w` in 5: destination register per stage.
- `reg_write_e`, `reg_write_m`, `reg_write_w` in 1: register-write enable per stage.
- `mem_to_reg_e`, `mem_to_reg_m` in 1: the instruction in that stage is a load.
- `branch_d` in 1: decode holds a branch that compares registers.
- `pc_src_d` in 1: branch taken, resolved in decode.
- `jump_d` in 1: decode holds a jump.
- `md_start_e` in 1: execute issues a mult/div this cycle.
- `md_read_d` in 1: decode holds mfhi/mflo.
- `enable_f`, `enable_d` out 1: PC and decode-register enables.
- `clr_d`, `clr_e` out 1: decode- and execute-register clears.
- `fwd_a_d`, `fwd_b_d` out 1: decode comparator forwards from memory stage.
- `fwd_a_e`, `fwd_b_e` out 2: ALU operand select: 00 = register file, 01 = writeback, 10 = memory.
- `md_busy` out 1: the mult/div result is not ready.

## Operation
- The zero register never matches. Every register-equality term also requires the register number ≠ 0.
- `fwd_a_e`: 10 if `rs_e`==`write_reg_m`&&`reg_write_m`, else 01 if `rs_e`==`write_reg_w`&&`reg_write_w`, else 00. The memory-stage match has priority. `fwd_b_e` is the same with `rt_e`.
- `fwd_a_d` = `rs_d`==`write_reg_m`&&`reg_write_m`. `fwd_b_d` is the same with `rt_d`.
- lw_stall = `mem_to_reg_e` && (`rt_e`==`rs_d` || `rt_e`==`rt_d`).
- br_stall = `branch_d` && [(`reg_write_e` && `write_reg_e`∈{`rs_d`,`rt_d`}) || (`mem_to_reg_m` && `write_reg_m`∈{`rs_d`,`rt_d`})].
- md_stall = `md_read_d` && (`md_busy` || `md_start_e`).
- stall = lw_stall | br_stall | md_stall.
- Outputs from stall:
  - `enable_f` = `enable_d` = !stall.
  - `clr_e` = stall.
  - `clr_d` = (`pc_src_d` | `jump_d`) & !stall. A stall wins over a flush; the flush is re-evaluated once the stall clears.
- Mult/div counter, 8-bit `md_cnt`:
  - `md_start_e` loads `MD_LATENCY`. A start while busy restarts the count.
  - Otherwise, a nonzero count decrements by 1.
  - `md_busy` = `md_cnt`≠0.

## Timing
- All control outputs are combinational from the inputs and `md_cnt`, valid within the same cycle.
- The only state is `md_cnt` plus the optional counters.
- Reset: `md_cnt`=0 immediately on `rst` rising. While `rst`=1:
  - `enable_f`=`enable_d`=0
  - `clr_d`=`clr_e`=1
  - all `fwd_*`=0
  - `md_busy`=0
- Load-use hazard: exactly 1 stall cycle.
- Branch hazard: 1 cycle on an ALU dependency in E; 1 cycle on a load in M. A load in E gives 2 cycles total, E then M.
- mfhi/mflo immediately after a mult issue: stalled MD_LATENCY+1 cycles, then enabled in the cycle where `md_cnt` is 0.
- `md_start_e` and `md_cnt`==1 in the same cycle: reload wins, so the next value is `MD_LATENCY`.
- Reset asserted mid-count: count aborts to 0. No stall persists after `rst` falls.

## Configuration
- `PIPE_HAZARD_CTRL_PERF_EN` defined: adds two 32-bit outputs.
  - `stall_cnt` increments every cycle that stall=1.
  - `flush_cnt` increments every cycle that `clr_d`=1.
  - Both reset to 0, wrap from 0xFFFFFFFF to 0, and do not count while `rst`=1.
- Macro undefined: the ports and counters are absent and the behaviour is otherwise identical.

## Test plan
- Reset: `rst`=1 with `md_cnt` nonzero → `md_busy`=0, `enable_f`=0, `clr_e`=1. Release `rst` with all inputs 0 → `enable_f`=`enable_d`=1, `clr_d`=`clr_e`=0, `fwd_*`=0.
- Forwarding: `rs_e`=5, `write_reg_m`=5, `reg_write_m`=1, `write_reg_w`=5, `reg_write_w`=1 → `fwd_a_e`=10. Drop `reg_write_m` → 01. Set `rs_e`=0 → 00.
- Load-use: `mem_to_reg_e`=1, `rt_e`=8, `rs_d`=8 for one cycle → `enable_f`=`enable_d`=0, `clr_e`=1 for that cycle only.
- Branch plus flush: `branch_d`=1, `pc_src_d`=1, `rs_d`=3, `reg_write_e`=1, `write_reg_e`=3 → `clr_d`=0, stall=1. Next cycle with no E match → `clr_d`=1, enables=1.
- Mult/div with `MD_LATENCY`=4: pulse `md_start_e` with `md_read_d`=1 held → stall for 5 cycles, `md_busy` high for 4 cycles, enables high on the 6th cycle. Re-pulse start at `md_cnt`=1 → count returns to 4.
- Perf (macro defined): 3 load-use stalls and 2 jumps → `stall_cnt`=3, `flush_cnt`=2. Preload `stall_cnt`=0xFFFFFFFF, one stall → `stall_cnt`=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and forwarding control for the 5-stage MIPS pipeline, with a mult/div busy tracker.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic [4:0] write_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_e,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       mem_to_reg_e,
    input  logic       mem_to_reg_m,
    input  logic       branch_d,
    input  logic       pc_src_d,
    input  logic       jump_d,
    input  logic       md_start_e,
    input  logic       md_read_d,
    output logic       enable_f,
    output logic       enable_d,
    output logic       clr_d,
    output logic       clr_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       md_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY);

    logic [7:0] md_cnt_r;
    logic       md_busy_s;
    logic       lw_stall_s;
    logic       br_stall_s;
    logic       md_stall_s;
    logic       stall_s;
    logic       flush_s;
    logic [1:0] fwd_a_e_s;
    logic [1:0] fwd_b_e_s;

    // Register zero is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] alu_fwd(input logic [4:0] src);
        logic [1:0] sel;
        if (reg_write_m && reg_match(src, write_reg_m)) begin
            sel = 2'b10;
        end else if (reg_write_w && reg_match(src, write_reg_w)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign md_busy_s = (md_cnt_r != 8'd0);

    // Hazard detection and raw forwarding selects.
    always_comb begin
        lw_stall_s = mem_to_reg_e && (reg_match(rt_e, rs_d) || reg_match(rt_e, rt_d));
        br_stall_s = branch_d &&
                     ((reg_write_e && (reg_match(write_reg_e, rs_d) || reg_match(write_reg_e, rt_d))) ||
                      (mem_to_reg_m && (reg_match(write_reg_m, rs_d) || reg_match(write_reg_m, rt_d))));
        md_stall_s = md_read_d && (md_busy_s || md_start_e);
        stall_s    = lw_stall_s || br_stall_s || md_stall_s;
        flush_s    = (pc_src_d || jump_d) && !stall_s;
        fwd_a_e_s  = alu_fwd(rs_e);
        fwd_b_e_s  = alu_fwd(rt_e);
    end

    // Output drive; reset holds the pipeline frozen and cleared.
    always_comb begin
        enable_f = 1'b0;
        enable_d = 1'b0;
        clr_d    = 1'b1;
        clr_e    = 1'b1;
        fwd_a_d  = 1'b0;
        fwd_b_d  = 1'b0;
        fwd_a_e  = 2'b00;
        fwd_b_e  = 2'b00;
        md_busy  = 1'b0;
        if (rst) begin
            enable_f = 1'b0;
            enable_d = 1'b0;
        end else begin
            enable_f = !stall_s;
            enable_d = !stall_s;
            clr_d    = flush_s;
            clr_e    = stall_s;
            fwd_a_d  = reg_write_m && reg_match(rs_d, write_reg_m);
            fwd_b_d  = reg_write_m && reg_match(rt_d, write_reg_m);
            fwd_a_e  = fwd_a_e_s;
            fwd_b_e  = fwd_b_e_s;
            md_busy  = md_busy_s;
        end
    end

    // Mult/div busy counter; a new issue always restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_cnt_r <= 8'd0;
        end else if (md_start_e) begin
            md_cnt_r <= MD_LOAD;
        end else if (md_cnt_r != 8'd0) begin
            md_cnt_r <= md_cnt_r - 8'd1;
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // Stall and flush event counters, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_s ? (stall_cnt + 32'd1) : stall_cnt;
            flush_cnt <= flush_s ? (flush_cnt + 32'd1) : flush_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized cycles
// checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
    logic       branch_d, pc_src_d, jump_d, md_start_e, md_read_d;
    logic       enable_f, enable_d, clr_d, clr_e, fwd_a_d, fwd_b_d, md_busy;
    logic [1:0] fwd_a_e, fwd_b_e;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    int unsigned stall_m, flush_m;
`endif

    int tests = 0;
    int fails = 0;
    int model_cnt;
    bit exp_stall, exp_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
        .branch_d(branch_d), .pc_src_d(pc_src_d), .jump_d(jump_d),
        .md_start_e(md_start_e), .md_read_d(md_read_d),
        .enable_f(enable_f), .enable_d(enable_d), .clr_d(clr_d), .clr_e(clr_e),
        .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .md_busy(md_busy)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dep(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic int alu_src(input logic [4:0] r);
        if (reg_write_m && dep(r, write_reg_m)) return 2;
        if (reg_write_w && dep(r, write_reg_w)) return 1;
        return 0;
    endfunction

    // Compare every output with the reference model for the current inputs.
    task automatic check_all(input string tag);
        bit lw, br, md;
        lw = mem_to_reg_e && (dep(rt_e, rs_d) || dep(rt_e, rt_d));
        br = branch_d && ((reg_write_e && (dep(write_reg_e, rs_d) || dep(write_reg_e, rt_d))) ||
                          (mem_to_reg_m && (dep(write_reg_m, rs_d) || dep(write_reg_m, rt_d))));
        md = md_read_d && (model_cnt > 0 || md_start_e);
        exp_stall = lw | br | md;
        exp_flush = (pc_src_d | jump_d) & ~exp_stall;
        if (rst) begin
            model_cnt = 0;
            check({tag, ".en_f"}, 32'(enable_f), 32'd0);
            check({tag, ".en_d"}, 32'(enable_d), 32'd0);
            check({tag, ".clr_d"}, 32'(clr_d), 32'd1);
            check({tag, ".clr_e"}, 32'(clr_e), 32'd1);
            check({tag, ".fwd"}, 32'({fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}), 32'd0);
            check({tag, ".busy"}, 32'(md_busy), 32'd0);
        end else begin
            check({tag, ".en_f"}, 32'(enable_f), 32'(!exp_stall));
            check({tag, ".en_d"}, 32'(enable_d), 32'(!exp_stall));
            check({tag, ".clr_e"}, 32'(clr_e), 32'(exp_stall));
            check({tag, ".clr_d"}, 32'(clr_d), 32'(exp_flush));
            check({tag, ".fwd_a_d"}, 32'(fwd_a_d), 32'(reg_write_m && dep(rs_d, write_reg_m)));
            check({tag, ".fwd_b_d"}, 32'(fwd_b_d), 32'(reg_write_m && dep(rt_d, write_reg_m)));
            check({tag, ".fwd_a_e"}, 32'(fwd_a_e), 32'(alu_src(rs_e)));
            check({tag, ".fwd_b_e"}, 32'(fwd_b_e), 32'(alu_src(rt_e)));
            check({tag, ".busy"}, 32'(md_busy), 32'(model_cnt > 0));
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check({tag, ".stall_cnt"}, stall_cnt, stall_m);
        check({tag, ".flush_cnt"}, flush_cnt, flush_m);
`endif
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_cnt = 0;
        else begin
            if (md_start_e) model_cnt = LAT;
            else if (model_cnt > 0) model_cnt = model_cnt - 1;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
            if (exp_stall) stall_m++;
            if (exp_flush) flush_m++;
`endif
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rs_d = 5'd0; rt_d = 5'd0; rs_e = 5'd0; rt_e = 5'd0;
        write_reg_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
        reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0;
        branch_d = 1'b0; pc_src_d = 1'b0; jump_d = 1'b0;
        md_start_e = 1'b0; md_read_d = 1'b0;
    endtask

    initial begin
        model_cnt = 0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        stall_m = 0; flush_m = 0;
`endif
        rst = 1'b1;
        idle();
        @(negedge clk);
        #1 check_all("reset");
        tick();
        rst = 1'b0;
        #1 check_all("post_reset");
        check("idle.en_f", 32'(enable_f), 32'd1);
        check("idle.clr_e", 32'(clr_e), 32'd0);
        tick();

        // Forwarding priority.
        rs_e = 5'd5; write_reg_m = 5'd5; reg_write_m = 1'b1; write_reg_w = 5'd5; reg_write_w = 1'b1;
        #1 check("fwd.mem", 32'(fwd_a_e), 32'd2);
        check_all("fwd_mem");
        tick();
        reg_write_m = 1'b0;
        #1 check("fwd.wb", 32'(fwd_a_e), 32'd1);
        tick();
        rs_e = 5'd0;
        #1 check("fwd.zero", 32'(fwd_a_e), 32'd0);
        tick();
        idle();

        // Load-use: one stall cycle.
        mem_to_reg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8;
        #1 check("lw.en_f", 32'(enable_f), 32'd0);
        check("lw.clr_e", 32'(clr_e), 32'd1);
        tick();
        idle();
        #1 check("lw.after", 32'(enable_d), 32'd1);
        tick();

        // Branch stall beats taken-branch flush.
        branch_d = 1'b1; pc_src_d = 1'b1; rs_d = 5'd3; reg_write_e = 1'b1; write_reg_e = 5'd3;
        #1 check("br.clr_d", 32'(clr_d), 32'd0);
        check("br.stall", 32'(clr_e), 32'd1);
        tick();
        reg_write_e = 1'b0; write_reg_e = 5'd0;
        #1 check("br.flush", 32'(clr_d), 32'd1);
        check("br.en", 32'(enable_f), 32'd1);
        tick();
        idle();

        // mfhi right after mult issue: LAT+1 stalled cycles.
        md_read_d = 1'b1; md_start_e = 1'b1;
        #1 check("md.issue", 32'(enable_f), 32'd0);
        tick();
        md_start_e = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            #1 check("md.wait_en", 32'(enable_f), 32'd0);
            check("md.wait_busy", 32'(md_busy), 32'd1);
            tick();
        end
        #1 check("md.release", 32'(enable_f), 32'd1);
        check("md.idle", 32'(md_busy), 32'd0);
        md_read_d = 1'b0;
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0;
        tick(); tick(); tick();
        md_start_e = 1'b1;
        #1 check_all("md_restart");
        tick();
        md_start_e = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            #1 check("md.reload_busy", 32'(md_busy), 32'd1);
            tick();
        end
        #1 check("md.reload_done", 32'(md_busy), 32'd0);

        // Reset mid-count aborts the count and leaves no stall.
        md_start_e = 1'b1;
        tick();
        md_start_e = 1'b0;
        tick();
        rst = 1'b1;
        #1 check("rst.busy", 32'(md_busy), 32'd0);
        check("rst.en_f", 32'(enable_f), 32'd0);
        check("rst.clr_e", 32'(clr_e), 32'd1);
        tick();
        rst = 1'b0; md_read_d = 1'b1;
        #1 check("rst.nostall", 32'(enable_f), 32'd1);
        check_all("post_rst");
        tick();
        idle();

        // Jumps flush when nothing stalls.
        for (int k = 0; k < 2; k++) begin
            jump_d = 1'b1;
            #1 check_all("jump");
            tick();
        end
        idle();

        // Randomized cycles over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
            rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
            write_reg_e = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
            write_reg_w = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            mem_to_reg_e = 1'($urandom_range(0, 3) == 0); mem_to_reg_m = 1'($urandom_range(0, 3) == 0);
            branch_d = 1'($urandom); pc_src_d = 1'($urandom); jump_d = 1'($urandom_range(0, 3) == 0);
            md_start_e = 1'($urandom_range(0, 9) == 0); md_read_d = 1'($urandom_range(0, 2) == 0);
            rst = 1'($urandom_range(0, 49) == 0);
            #1 check_all("rand");
            tick();
        end
        rst = 1'b0;
        idle();
        #1 check_all("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
